// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects plus load-use stall/bubble control with saturating stall statistics
module fwd_hazard_unit #(
  parameter int REG_AW     = 3,
  parameter int LOAD_STALL = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count
);
  logic              s1_v_q, s1_rw_q, s1_mr_q, s2_v_q, s2_rw_q, s3_v_q, s3_rw_q;
  logic [REG_AW-1:0] s1_rs1_q, s1_rs2_q, s1_rd_q, s2_rd_q, s3_rd_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_count_q;
  logic              live1, live2, live3, hazard;
  always_comb begin
    live1  = s1_v_q & s1_rw_q & (ZERO_REG == 0 || s1_rd_q != '0);
    live2  = s2_v_q & s2_rw_q & (ZERO_REG == 0 || s2_rd_q != '0);
    live3  = s3_v_q & s3_rw_q & (ZERO_REG == 0 || s3_rd_q != '0);
    hazard = id_valid & live1 & s1_mr_q & (s1_rd_q == id_rs1 || s1_rd_q == id_rs2);
    stall  = ~flush & (hazard | cnt_q != 3'd0);
    bubble = stall | flush;
    fwd_a  = !s1_v_q ? 2'b00 : (live2 && s2_rd_q == s1_rs1_q) ? 2'b10 :
             (live3 && s3_rd_q == s1_rs1_q) ? 2'b01 : 2'b00;
    fwd_b  = !s1_v_q ? 2'b00 : (live2 && s2_rd_q == s1_rs2_q) ? 2'b10 :
             (live3 && s3_rd_q == s1_rs2_q) ? 2'b01 : 2'b00;
    cnt_d  = flush ? 3'd0 : (hazard && cnt_q == 3'd0) ? 3'(LOAD_STALL - 1) :
             cnt_q != 3'd0 ? cnt_q - 3'd1 : cnt_q;
  end
  assign stall_count = stall_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q        <= 1'b0;
      s1_rw_q       <= 1'b0;
      s1_mr_q       <= 1'b0;
      s1_rs1_q      <= '0;
      s1_rs2_q      <= '0;
      s1_rd_q       <= '0;
      s2_v_q        <= 1'b0;
      s2_rw_q       <= 1'b0;
      s2_rd_q       <= '0;
      s3_v_q        <= 1'b0;
      s3_rw_q       <= 1'b0;
      s3_rd_q       <= '0;
      cnt_q         <= 3'd0;
      stall_count_q <= '0;
    end else begin
      s3_v_q  <= s2_v_q;
      s3_rw_q <= s2_rw_q;
      s3_rd_q <= s2_rd_q;
      s2_v_q  <= s1_v_q;
      s2_rw_q <= s1_rw_q;
      s2_rd_q <= s1_rd_q;
      cnt_q   <= cnt_d;
      if (!bubble) begin
        s1_v_q   <= id_valid;
        s1_rw_q  <= id_regwrite;
        s1_mr_q  <= id_memread;
        s1_rs1_q <= id_rs1;
        s1_rs2_q <= id_rs2;
        s1_rd_q  <= id_rd;
      end else begin
        s1_v_q <= 1'b0;
      end
      if (stall && stall_count_q != '1) stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined MIPS core; successor to the single-source combinational forwarding check.
- Internally tracks destination info for ID/EX, EX/MEM and MEM/WB from decode-stage inputs.
- Drives 2-bit operand-forward selects for the EX stage, with EX/MEM priority over MEM/WB.
- Detects load-use hazards and holds the front end for a configurable number of cycles, inserting bubbles; keeps a saturating stall counter.

Parameters:
- REG_AW, 3, register address width.
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal range 1..7.
- ZERO_REG, 1, when 1, register 0 never forwards and never causes a hazard.
- CNT_W, 8, width of stall statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  taken branch/jump; kills the ID/EX slot and any pending stall.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1  in  REG_AW  decode source 1.
- id_rs2  in  REG_AW  decode source 2.
- id_rd  in  REG_AW  decode destination.
- id_regwrite  in  1  decode instruction writes rd.
- id_memread  in  1  decode instruction is a load.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- fwd_b  out  2  EX operand B select, same encoding.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  ID/EX receives a NOP this cycle.
- stall_count  out  CNT_W  total stall cycles, saturating.

Behaviour:
- Tracking slots:
  - S1 (ID/EX): v, rs1, rs2, rd, rw, mr.
  - S2 (EX/MEM): v, rd, rw, mr.
  - S3 (MEM/WB): v, rd, rw.
- "Live" source means a slot with v=1, rw=1, and (ZERO_REG=0 or rd≠0).
- Per clock, pipeline always advances: S3<=S2, S2<=S1.
- S1 loading:
  - S1 <= decode fields with v=id_valid, when not stall and not flush.
  - Otherwise S1.v <= 0 (bubble).
- hazard_now is combinational and true when all of the following hold:
  - id_valid=1;
  - S1 is a live load (mr=1);
  - S1.rd equals id_rs1 or id_rs2.
- Stall counter cnt (3 bits) and stall output:
  - stall = hazard_now or cnt≠0.
  - bubble = stall or flush.
  - When hazard_now and cnt=0: cnt <= LOAD_STALL-1.
  - Else when cnt≠0: cnt <= cnt-1.
- Forward select fwd_a, combinational from slots (fwd_b identical using S1.rs2):
  - 10 if S1.v and S2 live and S2.rd=S1.rs1;
  - else 01 if S3 live and S3.rd=S1.rs1;
  - else 00.
  - With S1.v=0, both selects are 00.
- A load in S2 never matches a dependent in S1, because hazard stalling guarantees separation. The bench asserts this never occurs.
- Flush:
  - Synchronous; S1.v <= 0 and cnt <= 0.
  - stall is forced 0 in the flush cycle; flush has priority over hazard_now.
  - S2 and S3 advance normally.
- stall_count increments by 1 on every cycle with stall=1 and saturates at all-ones.
- Regfile writes in first half-cycle, so no MEM/WB-to-ID forwarding is required.
- Reset (asynchronous, any time, including mid-stall):
  - all slot v=0, all fields 0, cnt=0, stall_count=0.
  - Outputs: fwd_a=fwd_b=00, stall=0, bubble=0.
- No latency on outputs beyond slot registers; selects are valid the same cycle the instruction occupies S1.

Test Plan:
- ALU chain: add r1 (rd=1,rw=1), then add rs1=1, then add rs2=1 back-to-back → cycle 2 fwd_a=10; cycle 3 fwd_b=01 (from S3) and fwd_a=00 for third if unrelated; stall never 1.
- Load-use, LOAD_STALL=1: lw rd=2 (mr=1), then add rs1=2 → stall=1 and bubble=1 for exactly 1 cycle; next cycle fwd_a=01; stall_count=1.
- Load-use, LOAD_STALL=3: same sequence → stall high 3 consecutive cycles, three S1 bubbles; stall_count=3; dependent then sees fwd_a=00 (load retired, regfile path).
- Zero register, ZERO_REG=1: rd=0 rw=1, then rs1=0 → fwd_a=00; lw rd=0 then rs1=0 → no stall. With ZERO_REG=0 → fwd_a=10, stall=1.
- Flush mid-stall: LOAD_STALL=3, assert flush in 2nd stall cycle → stall=0 that cycle and after, cnt cleared, bubble=1 in flush cycle; older S2/S3 forwarding unaffected.
- Async reset mid-stall: drop rst_n between edges during stall with 5 counted stalls → stall, bubble, fwd_a, fwd_b, stall_count all 0 immediately; after release, first instruction produces no spurious forward. Saturation run with CNT_W=4 → stall_count holds at 15.
